// File: rtl/sevseg_rx_pkg.sv
// Shared 7-segment definitions: active-low codes (bit 0 = seg a,
// bit 6 = seg g) used by both the display encoder and the receiver.
package sevseg_rx_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int CNT_W = 8;

  function automatic logic [6:0] seg_encode(
    input logic [3:0] nib
  );
    logic [6:0] c;
    c = SEG_BLANK;
    unique case (nib)
      4'h0: c = SEG_0;
      4'h1: c = SEG_1;
      4'h2: c = SEG_2;
      4'h3: c = SEG_3;
      4'h4: c = SEG_4;
      4'h5: c = SEG_5;
      4'h6: c = SEG_6;
      4'h7: c = SEG_7;
      4'h8: c = SEG_8;
      4'h9: c = SEG_9;
      4'hA: c = SEG_A;
      4'hB: c = SEG_B;
      4'hC: c = SEG_C;
      4'hD: c = SEG_D;
      4'hE: c = SEG_E;
      4'hF: c = SEG_F;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sevseg_decode.sv
// One-digit 7-segment decoder: code_i (active-low) -> nibble_o,
// legal_o low for blank or any code outside the hex table.
module sevseg_decode
  import sevseg_rx_pkg::*;
(
  input  logic [6:0] code_i,
  output logic [3:0] nibble_o,
  output logic       legal_o
);

  always_comb begin
    nibble_o = 4'h0;
    legal_o  = 1'b1;
    unique case (code_i)
      SEG_0:   nibble_o = 4'h0;
      SEG_1:   nibble_o = 4'h1;
      SEG_2:   nibble_o = 4'h2;
      SEG_3:   nibble_o = 4'h3;
      SEG_4:   nibble_o = 4'h4;
      SEG_5:   nibble_o = 4'h5;
      SEG_6:   nibble_o = 4'h6;
      SEG_7:   nibble_o = 4'h7;
      SEG_8:   nibble_o = 4'h8;
      SEG_9:   nibble_o = 4'h9;
      SEG_A:   nibble_o = 4'hA;
      SEG_B:   nibble_o = 4'hB;
      SEG_C:   nibble_o = 4'hC;
      SEG_D:   nibble_o = 4'hD;
      SEG_E:   nibble_o = 4'hE;
      SEG_F:   nibble_o = 4'hF;
      default: legal_o  = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevseg_rx.sv
// 7-segment receiver: recovers hex nibbles from a stable HEX bus.
// Ports: clk, rst_n, segments in; number, valid, error, update out.
module sevseg_rx
  import sevseg_rx_pkg::*;
#(
  parameter int DIGITS        = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7*DIGITS-1:0]   segments,
  output logic [4*DIGITS-1:0]   number,
  output logic                  valid,
  output logic                  error,
  output logic                  update
);

  localparam logic [CNT_W-1:0] STAB =
    CNT_W'(STABLE_CYCLES);

  logic [7*DIGITS-1:0] seg_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                armed_q;
  logic                armed_d;
  logic [4*DIGITS-1:0] num_q;
  logic [4*DIGITS-1:0] num_d;
  logic                valid_q;
  logic                valid_d;
  logic                err_q;
  logic                err_d;
  logic                upd_q;
  logic                accept;

  logic [4*DIGITS-1:0] nib;
  logic [DIGITS-1:0]   legal;

  // Decode the sampled copy; at acceptance it equals segments.
  for (genvar k = 0; k < DIGITS; k++) begin : g_dec
    sevseg_decode u_dec (
      .code_i   (seg_q[7*k +: 7]),
      .nibble_o (nib[4*k +: 4]),
      .legal_o  (legal[k])
    );
  end

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    accept  = 1'b0;
    num_d   = num_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (segments != seg_q) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (cnt_q < STAB) begin
      cnt_d = cnt_q + 1'b1;
      // Fire once on the final step of the window.
      if (armed_q && cnt_q == STAB - 1'b1) begin
        accept  = 1'b1;
        armed_d = 1'b0;
      end
    end
    if (accept) begin
      if (&legal) begin
        num_d   = nib;
        valid_d = 1'b1;
        err_d   = 1'b0;
      end else begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= '1;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      num_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      seg_q   <= segments;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      num_q   <= num_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      upd_q   <= accept;
    end
  end

  assign number = num_q;
  assign valid  = valid_q;
  assign error  = err_q;
  assign update = upd_q;

endmodule

// File: doc/sevseg_rx.md
Name: sevseg_rx

Overview:
- Receive side of the 7-segment display path: takes active-low segment patterns, as driven to HEX displays, and recovers the hex nibbles behind them.
- A pattern is accepted only after it has been stable for a programmable number of cycles.
- Used as an on-board loopback checker: the HEX bus feeds back in, and the recovered byte is compared against the switch/adder value.
- Flags illegal or blank patterns instead of producing a number.

Parameters:
- DIGITS, 2: number of 7-segment digits decoded. Digit 0 is the least-significant nibble.
- STABLE_CYCLES, 4: consecutive cycles an unchanged pattern must hold before acceptance. Legal range 1..255.

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- rst_n  input  1  asynchronous active-low reset
- segments  input  7*DIGITS  active-low segments. Digit k occupies bits [7k+6:7k]; bit 7k = seg a ... bit 7k+6 = seg g.
- number  output  4*DIGITS  last accepted value. Digit k is on [4k+3:4k].
- valid  output  1  high while number reflects the currently accepted, fully legal pattern.
- error  output  1  high while the last stable pattern contained at least one illegal digit.
- update  output  1  single-cycle pulse on each acceptance (legal or illegal).

Behaviour:
- Reset (async assert, synchronous-release use assumed upstream): number=0, valid=0, error=0, update=0, seg_q=all ones (blank), cnt=0, armed=1.
- Sampling register, every edge: seg_q <= segments.
  - If segments != seg_q: cnt <= 0, armed <= 1.
  - Else if cnt < STABLE_CYCLES: cnt <= cnt+1.
- Acceptance edge: the edge where cnt goes STABLE_CYCLES-1 -> STABLE_CYCLES while armed=1. On that edge armed <= 0 and update <= 1. On all other edges update <= 0.
  - All digits legal: number <= decoded nibbles, valid <= 1, error <= 0.
  - Any digit illegal: number holds, valid <= 0, error <= 1.
- Latency: input held constant from edge E (first edge it is sampled into seg_q) -> outputs change after edge E+STABLE_CYCLES. update is high for exactly that one cycle.
- Re-acceptance: none while the input stays constant (armed=0). Any change re-arms and restarts the count.
- Glitch rejection: a change of fewer than STABLE_CYCLES+1 sampled cycles followed by a return to the old pattern still re-arms, so the old pattern is accepted again with an update pulse. valid/error keep their previous values in between.
- Instability: while the input is changing, valid/error/number hold. valid does not drop just because the input is unstable.
- Saturation: cnt saturates at STABLE_CYCLES; no wrap.
- Decode table (active-low, g..a):
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
  - A = 0001000
  - b = 0000011
  - C = 1000110
  - d = 0100001
  - E = 0000110
  - F = 0001110
- Any other code, including blank 1111111, is illegal.
- Reset mid-count: all state returns to reset values immediately. The first acceptance after release requires a full STABLE_CYCLES window.
- STABLE_CYCLES=1: a pattern is accepted on the first edge where segments == seg_q.

Decomposition:
- Shared package holds the 16 segment-code constants (SEG_0..SEG_F, 7-bit active-low) and SEG_BLANK. The existing sevseg encoder and this block use the same constants.
- One sub-module, sevseg_decode: combinational, 7-bit code in -> 4-bit nibble plus legal flag. Instantiated DIGITS times in a generate loop.
- sevseg_rx holds only the register, counter, arm flag and output registers.

Test Plan:
- Reset, then segments={1111001,0000010} (digit1=1, digit0=6) held: update pulses once after 4+1 edges; number=8'h16, valid=1, error=0; no second pulse over 20 further cycles.
- Sweep all 16 legal codes on digit0, digit1=0, each held 6 cycles: number=8'h00..8'h0F in order, 16 update pulses, error never set.
- Digit1=1111111 (blank), digit0=0: update pulse, error=1, valid=0, number keeps the previous value 8'h0F.
- Accept 8'h42, then 2-cycle glitch to 8'h43, then back to 8'h42: 8'h43 is never accepted; 8'h42 is re-accepted with one update pulse; valid stays 1 throughout.
- Apply 8'hAB stable, assert rst_n low at cnt=2, release: outputs 0 immediately; acceptance of 8'hAB occurs STABLE_CYCLES edges after the first post-reset sample.
- STABLE_CYCLES=1 build: input changes every 2 cycles through 8'hC3, 8'h5A: each value is accepted with one update pulse per value.
